// File: rtl/mem_bus_pkg.sv
// Shared target encoding, priority decode helper and the default SoC region map
// for the Vicuna/Ibex data-memory router.
package mem_bus_pkg;

    localparam int MAX_SLV = 8;

    // Wide enough for MAX_SLV regions plus the decode-error encoding
    typedef logic [$clog2(MAX_SLV + 1)-1:0] tgt_t;

    localparam logic [31:0] SRAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] SRAM_MASK      = 32'hFFF0_0000;
    localparam logic [31:0] GPIO_BASE      = 32'h1000_0000;
    localparam logic [31:0] GPIO_MASK      = 32'hFFFF_F000;
    localparam logic [31:0] FLASH_SPI_BASE = 32'h2000_0000;
    localparam logic [31:0] FLASH_SPI_MASK = 32'hFF00_0000;
    // Programming SPI window encloses the flash window; flash wins by priority
    localparam logic [31:0] PROG_SPI_BASE  = 32'h2000_0000;
    localparam logic [31:0] PROG_SPI_MASK  = 32'hF000_0000;

    localparam logic [4*32-1:0] SOC_SLV_BASE =
        {PROG_SPI_BASE, FLASH_SPI_BASE, GPIO_BASE, SRAM_BASE};
    localparam logic [4*32-1:0] SOC_SLV_MASK =
        {PROG_SPI_MASK, FLASH_SPI_MASK, GPIO_MASK, SRAM_MASK};

    function automatic tgt_t decerr_tgt(input int num_slv);
        return tgt_t'(num_slv);
    endfunction

    function automatic tgt_t addr_decode(input logic [MAX_SLV-1:0] hit,
                                         input int num_slv);
        tgt_t t;
        t = decerr_tgt(num_slv);
        for (int i = MAX_SLV - 1; i >= 0; i--) begin
            if (i < num_slv && hit[i]) t = tgt_t'(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational region decoder: per-region hit vector and lowest-index target,
// with NUM_SLV meaning no enabled region matched.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
    parameter int TGT_W = $clog2(NUM_SLV + 1)
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic [NUM_SLV-1:0] region_en,
    output logic [NUM_SLV-1:0] hit,
    output logic [TGT_W-1:0]   tgt
);

    logic [MAX_SLV-1:0] hit_ext;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            hit[i] = region_en[i] &&
                     ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
        end
        hit_ext = MAX_SLV'(hit);
        tgt     = TGT_W'(addr_decode(hit_ext, NUM_SLV));
    end

endmodule

// File: rtl/mem_bus_router.sv
// Routes the core data-memory request stream to NUM_SLV address regions with a
// bounded number of outstanding requests, all to one target so responses stay in order.
module mem_bus_router
    import mem_bus_pkg::*;
#(
    parameter int MEM_W   = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int MAX_OUT = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SLV-1:0]       region_en_i,
    input  logic                     host_req_i,
    output logic                     host_gnt_o,
    input  logic [ADDR_W-1:0]        host_addr_i,
    input  logic                     host_we_i,
    input  logic [MEM_W/8-1:0]       host_be_i,
    input  logic [MEM_W-1:0]         host_wdata_i,
    output logic                     host_rvalid_o,
    output logic                     host_err_o,
    output logic [MEM_W-1:0]         host_rdata_o,
    output logic [NUM_SLV-1:0]       slv_req_o,
    input  logic [NUM_SLV-1:0]       slv_gnt_i,
    output logic [ADDR_W-1:0]        slv_addr_o,
    output logic                     slv_we_o,
    output logic [MEM_W/8-1:0]       slv_be_o,
    output logic [MEM_W-1:0]         slv_wdata_o,
    input  logic [NUM_SLV-1:0]       slv_rvalid_i,
    input  logic [NUM_SLV-1:0]       slv_err_i,
    input  logic [NUM_SLV*MEM_W-1:0] slv_rdata_i,
    output logic                     stray_rsp_o
);

    localparam int TGT_W = $clog2(NUM_SLV + 1);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [TGT_W-1:0] DECERR  = TGT_W'(decerr_tgt(NUM_SLV));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [NUM_SLV-1:0] hit;
    logic [TGT_W-1:0]   tgt;
    logic [TGT_W-1:0]   cur_tgt;
    logic [CNT_W-1:0]   cnt;
    logic               dec_miss;
    logic               allow;
    logic               stray_now;

    mem_bus_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .TGT_W    (TGT_W)
    ) u_decoder (
        .addr      (host_addr_i),
        .region_en (region_en_i),
        .hit       (hit),
        .tgt       (tgt)
    );

    assign dec_miss    = ~|hit;
    assign allow       = (cnt < CNT_MAX) && ((cnt == '0) || (tgt == cur_tgt));
    assign slv_addr_o  = host_addr_i;
    assign slv_we_o    = host_we_i;
    assign slv_be_o    = host_be_i;
    assign slv_wdata_o = host_wdata_i;

    // Request steering never looks at slv_gnt_i, so slaves may grant combinationally
    always_comb begin
        slv_req_o  = '0;
        host_gnt_o = 1'b0;
        if (!rst && host_req_i && allow) begin
            host_gnt_o = dec_miss;
            for (int i = 0; i < NUM_SLV; i++) begin
                if (tgt == TGT_W'(i)) begin
                    slv_req_o[i] = 1'b1;
                    host_gnt_o   = slv_gnt_i[i];
                end
            end
        end
    end

    always_comb begin
        host_rvalid_o = 1'b0;
        host_err_o    = 1'b0;
        host_rdata_o  = '0;
        stray_now     = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_rvalid_i[i] && ((cnt == '0) || (cur_tgt != TGT_W'(i)))) stray_now = 1'b1;
        end
        if (!rst && cnt != '0) begin
            if (cur_tgt == DECERR) begin
                host_rvalid_o = 1'b1;
                host_err_o    = 1'b1;
            end else begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (cur_tgt == TGT_W'(i) && slv_rvalid_i[i]) begin
                        host_rvalid_o = 1'b1;
                        host_err_o    = slv_err_i[i];
                        host_rdata_o  = slv_rdata_i[i*MEM_W +: MEM_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            cur_tgt     <= '0;
            stray_rsp_o <= 1'b0;
        end else begin
            if (host_gnt_o) cur_tgt <= tgt;
            if (host_gnt_o && !host_rvalid_o) begin
                cnt <= cnt + 1'b1;
            end else if (!host_gnt_o && host_rvalid_o) begin
                cnt <= cnt - 1'b1;
            end
            if (stray_now) stray_rsp_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_router.sv
// Self-checking bench for mem_bus_router: directed scenarios followed by random
// traffic, all compared against a queue-based model of outstanding targets.
module tb_mem_bus_router;
    import mem_bus_pkg::*;

    localparam int MEM_W   = 32;
    localparam int ADDR_W  = 32;
    localparam int NUM_SLV = 4;
    localparam int MAX_OUT = 4;
    localparam int BE_W    = MEM_W / 8;

    localparam logic [31:0] REF_BASE [NUM_SLV] = '{SRAM_BASE, GPIO_BASE, FLASH_SPI_BASE, PROG_SPI_BASE};
    localparam logic [31:0] REF_MASK [NUM_SLV] = '{SRAM_MASK, GPIO_MASK, FLASH_SPI_MASK, PROG_SPI_MASK};

    localparam logic [3:0]  ALL   = 4'hF;
    localparam logic [31:0] SRAM  = 32'h0000_0100;
    localparam logic [31:0] FLASH = 32'h2000_0040;
    localparam logic [31:0] BAD   = 32'hDEAD_0000;

    logic                     clk;
    logic                     rst;
    logic [NUM_SLV-1:0]       region_en;
    logic                     host_req;
    logic                     host_gnt;
    logic [ADDR_W-1:0]        host_addr;
    logic                     host_we;
    logic [BE_W-1:0]          host_be;
    logic [MEM_W-1:0]         host_wdata;
    logic                     host_rvalid;
    logic                     host_err;
    logic [MEM_W-1:0]         host_rdata;
    logic [NUM_SLV-1:0]       slv_req;
    logic [NUM_SLV-1:0]       slv_gnt;
    logic [ADDR_W-1:0]        slv_addr;
    logic                     slv_we;
    logic [BE_W-1:0]          slv_be;
    logic [MEM_W-1:0]         slv_wdata;
    logic [NUM_SLV-1:0]       slv_rvalid;
    logic [NUM_SLV-1:0]       slv_err;
    logic [NUM_SLV*MEM_W-1:0] slv_rdata;
    logic                     stray_rsp;

    int errors = 0;
    int checks = 0;
    int gnt_seen = 0;
    int rvalid_seen = 0;

    int out_q[$];
    bit exp_stray = 1'b0;
    int exp_tgt;
    bit exp_gnt;
    bit exp_rvalid;
    bit exp_stray_now;

    mem_bus_router #(
        .MEM_W    (MEM_W),
        .ADDR_W   (ADDR_W),
        .NUM_SLV  (NUM_SLV),
        .MAX_OUT  (MAX_OUT),
        .SLV_BASE (SOC_SLV_BASE),
        .SLV_MASK (SOC_SLV_MASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .region_en_i   (region_en),
        .host_req_i    (host_req),
        .host_gnt_o    (host_gnt),
        .host_addr_i   (host_addr),
        .host_we_i     (host_we),
        .host_be_i     (host_be),
        .host_wdata_i  (host_wdata),
        .host_rvalid_o (host_rvalid),
        .host_err_o    (host_err),
        .host_rdata_o  (host_rdata),
        .slv_req_o     (slv_req),
        .slv_gnt_i     (slv_gnt),
        .slv_addr_o    (slv_addr),
        .slv_we_o      (slv_we),
        .slv_be_o      (slv_be),
        .slv_wdata_o   (slv_wdata),
        .slv_rvalid_i  (slv_rvalid),
        .slv_err_i     (slv_err),
        .slv_rdata_i   (slv_rdata),
        .stray_rsp_o   (stray_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int refDecode(input logic [31:0] a, input logic [NUM_SLV-1:0] en);
        for (int i = 0; i < NUM_SLV; i++) begin
            if (en[i] && ((a & REF_MASK[i]) == REF_BASE[i])) return i;
        end
        return NUM_SLV;
    endfunction

    task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from the queue of outstanding targets and this cycle's inputs
    task automatic checkOutput();
        int n;
        int head;
        bit allow;
        logic [NUM_SLV-1:0] e_req;
        bit e_err;
        logic [MEM_W-1:0] e_rdata;

        n       = out_q.size();
        head    = (n > 0) ? out_q[0] : -1;
        exp_tgt = refDecode(host_addr, region_en);
        allow   = (n < MAX_OUT) && ((n == 0) ? 1'b1 : (exp_tgt == out_q[n-1]));

        e_req   = '0;
        exp_gnt = 1'b0;
        if (!rst && host_req && allow) begin
            if (exp_tgt == NUM_SLV) begin
                exp_gnt = 1'b1;
            end else begin
                e_req[exp_tgt] = 1'b1;
                exp_gnt        = slv_gnt[exp_tgt];
            end
        end

        exp_rvalid = 1'b0;
        e_err      = 1'b0;
        e_rdata    = '0;
        if (!rst && n > 0) begin
            if (head == NUM_SLV) begin
                exp_rvalid = 1'b1;
                e_err      = 1'b1;
            end else if (slv_rvalid[head]) begin
                exp_rvalid = 1'b1;
                e_err      = slv_err[head];
                e_rdata    = slv_rdata[head*MEM_W +: MEM_W];
            end
        end

        exp_stray_now = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_rvalid[i] && head != i) exp_stray_now = 1'b1;
        end

        if (host_gnt === 1'b1) gnt_seen++;
        if (host_rvalid === 1'b1) rvalid_seen++;

        checkOne("host_gnt",    64'(host_gnt),    64'(exp_gnt));
        checkOne("slv_req",     64'(slv_req),     64'(e_req));
        checkOne("host_rvalid", 64'(host_rvalid), 64'(exp_rvalid));
        checkOne("host_err",    64'(host_err),    64'(e_err));
        checkOne("host_rdata",  64'(host_rdata),  64'(e_rdata));
        checkOne("stray_rsp",   64'(stray_rsp),   64'(exp_stray));
        checkOne("slv_addr",    64'(slv_addr),    64'(host_addr));
        checkOne("slv_fields",  64'({slv_we, slv_be, slv_wdata}), 64'({host_we, host_be, host_wdata}));
    endtask

    task automatic updateModel();
        if (rst) begin
            out_q.delete();
            exp_stray = 1'b0;
        end else begin
            if (exp_rvalid) void'(out_q.pop_front());
            if (exp_gnt) out_q.push_back(exp_tgt);
            if (exp_stray_now) exp_stray = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] en, input bit req,
                                 input logic [31:0] addr, input bit we, input logic [3:0] gnt,
                                 input logic [3:0] rv, input logic [3:0] er);
        @(negedge clk);
        rst        = r;
        region_en  = en;
        host_req   = req;
        host_addr  = addr;
        host_we    = we;
        host_be    = BE_W'($urandom_range(0, 15));
        host_wdata = $urandom();
        slv_gnt    = gnt;
        slv_rvalid = rv;
        slv_err    = er;
        for (int i = 0; i < NUM_SLV; i++) slv_rdata[i*MEM_W +: MEM_W] = $urandom();
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
    endtask

    initial begin
        logic [31:0] raddr;
        logic [3:0]  ren;
        logic [3:0]  rrv;
        int          head;
        int          pick;

        rst        = 1'b1;
        region_en  = ALL;
        host_req   = 1'b0;
        host_addr  = '0;
        host_we    = 1'b0;
        host_be    = '0;
        host_wdata = '0;
        slv_gnt    = '0;
        slv_rvalid = '0;
        slv_err    = '0;
        slv_rdata  = '0;

        applyStimulus(1'b1, ALL, 1'b1, SRAM, 1'b0, ALL, ALL, 4'h0);
        applyStimulus(1'b1, ALL, 1'b1, BAD,  1'b0, ALL, ALL, ALL);

        // Back-to-back reads to SRAM with one-cycle response latency
        gnt_seen    = 0;
        rvalid_seen = 0;
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, ALL, 1'b1, 32'(32'h10 + 4 * k), 1'b0, ALL, (k > 0) ? 4'b0001 : 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0001, 4'h0);
        checkOne("burst_gnts", 64'(gnt_seen), 64'd4);
        checkOne("burst_rvalids", 64'(rvalid_seen), 64'd4);

        // Outstanding limit, then a single response frees exactly one slot
        gnt_seen = 0;
        repeat (10) applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("max_out_gnts", 64'(gnt_seen), 64'(MAX_OUT));
        applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0001, 4'h0);
        gnt_seen = 0;
        applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("regrant_after_rvalid", 64'(gnt_seen), 64'd1);
        repeat (4) applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0001, 4'h0);

        // Accept and response together one below the limit
        repeat (3) applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0001, 4'h0);
        gnt_seen = 0;
        applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("simul_then_full", 64'(gnt_seen), 64'd1);
        repeat (4) applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0001, 4'h0);

        // Target switch waits for the previous slave to drain
        applyStimulus(1'b0, ALL, 1'b1, SRAM,  1'b1, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b1, FLASH, 1'b0, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b1, FLASH, 1'b0, ALL, 4'b0001, 4'h0);
        gnt_seen = 0;
        applyStimulus(1'b0, ALL, 1'b1, FLASH, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("switch_gnt", 64'(gnt_seen), 64'd1);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0100, 4'h0);

        // Decode errors: unmapped address and disabled region; overlap priority
        applyStimulus(1'b0, ALL, 1'b1, BAD, 1'b0, 4'h0, 4'b0000, 4'h0);
        rvalid_seen = 0;
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, 4'h0, 4'b0000, 4'h0);
        checkOne("decerr_rsp", 64'(rvalid_seen), 64'd1);
        applyStimulus(1'b0, 4'b1110, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b1, 32'h2000_0000, 1'b0, 4'b0100, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0100, 4'h0);
        applyStimulus(1'b0, 4'b1011, 1'b1, 32'h2000_0000, 1'b0, 4'b1000, 4'b0000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b1000, 4'b1000);

        // Stray response with nothing outstanding, then reset mid-burst
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b1000, 4'h0);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("stray_sticky", 64'(stray_rsp), 64'd1);
        repeat (3) applyStimulus(1'b0, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0000, 4'h0);
        applyStimulus(1'b1, ALL, 1'b1, SRAM, 1'b0, ALL, 4'b0001, 4'h0);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("stray_cleared", 64'(stray_rsp), 64'd0);
        gnt_seen = 0;
        applyStimulus(1'b0, ALL, 1'b1, FLASH, 1'b0, ALL, 4'b0000, 4'h0);
        checkOne("post_reset_switch", 64'(gnt_seen), 64'd1);
        applyStimulus(1'b0, ALL, 1'b0, 32'h0, 1'b0, ALL, 4'b0100, 4'h0);

        // Random traffic: only the head target's slave answers, with rare strays and resets
        for (int c = 0; c < 3000; c++) begin
            pick = $urandom_range(0, 4);
            case (pick)
                0:       raddr = SRAM_BASE | ($urandom() & 32'h000F_FFFC);
                1:       raddr = GPIO_BASE | ($urandom() & 32'h0000_0FFC);
                2:       raddr = FLASH_SPI_BASE | ($urandom() & 32'h00FF_FFFC);
                3:       raddr = 32'h2100_0000 | ($urandom() & 32'h00FF_FFFC);
                default: raddr = BAD | ($urandom() & 32'h0000_FFFC);
            endcase
            ren = ALL;
            for (int i = 0; i < NUM_SLV; i++)
                if ($urandom_range(0, 7) == 0) ren[i] = 1'b0;
            head = (out_q.size() > 0) ? out_q[0] : -1;
            rrv  = 4'h0;
            if (head >= 0 && head < NUM_SLV && $urandom_range(0, 1) == 1) rrv[head] = 1'b1;
            if ($urandom_range(0, 127) == 0) begin
                pick = $urandom_range(0, NUM_SLV - 1);
                if (pick != head) rrv[pick] = 1'b1;
            end
            applyStimulus(($urandom_range(0, 63) == 0), ren, ($urandom_range(0, 3) != 0), raddr,
                          1'($urandom_range(0, 1)), 4'($urandom() | $urandom()), rrv,
                          ($urandom_range(0, 7) == 0) ? ALL : 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
